// File: rtl/multi_table_stream_decoder_pkg.sv
// Shared types and width helpers for the table-driven prefix-code decoder.
package multi_table_stream_decoder_pkg;

    // Default geometry; the table entry record is sized from these.
    localparam int DEF_WIDTH_OUT       = 8;
    localparam int DEF_MAX_CODE_LENGTH = 8;
    localparam int DEF_NUM_TABLES      = 2;

    // Code-width field must be able to hold MAX_CODE_LENGTH itself.
    function automatic int cw_bits(input int max_code_length);
        return $clog2(max_code_length) + 1;
    endfunction

    function automatic int tsel_bits(input int num_tables);
        return (num_tables > 1) ? $clog2(num_tables) : 1;
    endfunction

    localparam int ENTRY_CW_W = cw_bits(DEF_MAX_CODE_LENGTH);

    typedef enum logic {
        ST_LOOKUP = 1'b0,
        ST_ESC    = 1'b1
    } state_e;

    // cw == 0 marks an invalid entry; data is unused for escape entries.
    typedef struct packed {
        logic [ENTRY_CW_W-1:0]    cw;
        logic                     esc;
        logic [DEF_WIDTH_OUT-1:0] data;
    } entry_t;

endpackage

// File: rtl/multi_table_stream_decoder_vld_bit_buffer.sv
// Left-justified bit buffer: appends input words behind the valid bits and
// drops consumed bits from the top, both in the same cycle if needed.
module vld_bit_buffer #(
    parameter int WIDTH_IN        = 8,
    parameter int WIDTH_OUT       = 8,
    parameter int MAX_CODE_LENGTH = 8,
    parameter int BUF_BITS        = 32,
    parameter int CNT_W           = $clog2(BUF_BITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH_IN-1:0]        d_i,
    input  logic [CNT_W-1:0]           consume_i,
    output logic [CNT_W-1:0]           count_o,
    output logic                       full_o,
    output logic                       half_full_o,
    output logic [MAX_CODE_LENGTH-1:0] window_o,
    output logic [WIDTH_OUT-1:0]       head_o
);

    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]    count_q, count_d, remain;
    logic                push_ok;

    // Bits below count are always zero, so the window pads itself.
    assign count_o     = count_q;
    assign full_o      = count_q > CNT_W'(BUF_BITS - WIDTH_IN);
    assign half_full_o = count_q >= CNT_W'(BUF_BITS / 2);
    assign window_o    = buf_q[BUF_BITS-1 -: MAX_CODE_LENGTH];
    assign head_o      = buf_q[BUF_BITS-1 -: WIDTH_OUT];

    // Shift out consumed bits, then drop the new word right behind what is left.
    always_comb begin
        push_ok = push_i && !full_o;
        remain  = count_q - consume_i;
        buf_d   = buf_q << consume_i;
        count_d = remain;
        if (push_ok) begin
            buf_d   = buf_d | ({d_i, {(BUF_BITS - WIDTH_IN){1'b0}}} >> remain);
            count_d = remain + CNT_W'(WIDTH_IN);
        end
    end

    // Buffer and fill-level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multi_table_stream_decoder.sv
// Multi-table prefix-code decoder with escape literals, output backpressure
// and a sticky invalid-code flag.
module multi_table_stream_decoder
    import multi_table_stream_decoder_pkg::*;
#(
    parameter int WIDTH_IN        = 8,
    parameter int WIDTH_OUT       = DEF_WIDTH_OUT,
    parameter int MAX_CODE_LENGTH = DEF_MAX_CODE_LENGTH,
    parameter int NUM_TABLES      = DEF_NUM_TABLES,
    parameter int BUF_BITS        = 32,
    parameter int CW_BITS         = cw_bits(MAX_CODE_LENGTH),
    parameter int TSEL_BITS       = tsel_bits(NUM_TABLES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH_IN-1:0]        d,
    output logic                       full,
    output logic                       half_full,
    output logic [WIDTH_OUT-1:0]       q,
    output logic                       q_valid,
    input  logic                       pop,
    input  logic [TSEL_BITS-1:0]       active_table,
    input  logic                       table_push,
    input  logic [TSEL_BITS-1:0]       table_sel,
    input  logic [MAX_CODE_LENGTH-1:0] table_addr,
    input  logic [CW_BITS-1:0]         table_code_width,
    input  logic                       table_escape,
    input  logic [WIDTH_OUT-1:0]       table_data,
    output logic                       error
);

    localparam int DEPTH = 1 << MAX_CODE_LENGTH;
    localparam int CNT_W = $clog2(BUF_BITS + 1);

    entry_t                     tbl_q [NUM_TABLES][DEPTH];
    entry_t                     ent;
    state_e                     state_q, state_d;
    logic [WIDTH_OUT-1:0]       q_q, q_d, head;
    logic                       q_valid_q, q_valid_d, error_q, error_d, out_free;
    logic [CNT_W-1:0]           count, consume;
    logic [MAX_CODE_LENGTH-1:0] window;

    vld_bit_buffer #(
        .WIDTH_IN        (WIDTH_IN),
        .WIDTH_OUT       (WIDTH_OUT),
        .MAX_CODE_LENGTH (MAX_CODE_LENGTH),
        .BUF_BITS        (BUF_BITS),
        .CNT_W           (CNT_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .d_i         (d),
        .consume_i   (consume),
        .count_o     (count),
        .full_o      (full),
        .half_full_o (half_full),
        .window_o    (window),
        .head_o      (head)
    );

    assign q        = q_q;
    assign q_valid  = q_valid_q;
    assign error    = error_q;
    assign out_free = !q_valid_q || pop;

    // Table storage is not reset; an out-of-range table_sel is dropped.
    always_ff @(posedge clk) begin
        if (table_push && (32'(table_sel) < NUM_TABLES))
            tbl_q[table_sel][table_addr] <= '{cw: table_code_width, esc: table_escape, data: table_data};
    end

    // Combinational lookup; a nonexistent table reads as an invalid entry.
    always_comb begin
        ent = '0;
        if (32'(active_table) < NUM_TABLES)
            ent = tbl_q[active_table][window];
    end

    // Decode FSM: a table write stalls decode, pop alone just empties the slot.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        q_valid_d = q_valid_q && !pop;
        error_d   = error_q;
        consume   = '0;
        case (state_q)
            ST_LOOKUP: begin
                if (!table_push && !error_q) begin
                    if (ent.cw != '0) begin
                        if (out_free && count >= CNT_W'(ent.cw)) begin
                            consume = CNT_W'(ent.cw);
                            if (ent.esc) begin
                                state_d = ST_ESC;
                            end else begin
                                q_d       = ent.data;
                                q_valid_d = 1'b1;
                            end
                        end
                    end else if (count >= CNT_W'(MAX_CODE_LENGTH)) begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_ESC: begin
                if (out_free && !table_push && count >= CNT_W'(WIDTH_OUT)) begin
                    q_d       = head;
                    q_valid_d = 1'b1;
                    consume   = CNT_W'(WIDTH_OUT);
                    state_d   = ST_LOOKUP;
                end
            end
            default: state_d = ST_LOOKUP;
        endcase
    end

    // State, output slot and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOOKUP;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_multi_table_stream_decoder.sv
// Directed bench for multi_table_stream_decoder (default parameters).
module tb_multi_table_stream_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] d;
    logic       full, half_full;
    logic [7:0] q;
    logic       q_valid;
    logic       pop;
    logic [0:0] active_table;
    logic       table_push;
    logic [0:0] table_sel;
    logic [7:0] table_addr;
    logic [3:0] table_code_width;
    logic       table_escape;
    logic [7:0] table_data;
    logic       error;

    int errors = 0;
    int checks = 0;

    multi_table_stream_decoder dut (
        .clk              (clk),
        .rst              (rst),
        .push             (push),
        .d                (d),
        .full             (full),
        .half_full        (half_full),
        .q                (q),
        .q_valid          (q_valid),
        .pop              (pop),
        .active_table     (active_table),
        .table_push       (table_push),
        .table_sel        (table_sel),
        .table_addr       (table_addr),
        .table_code_width (table_code_width),
        .table_escape     (table_escape),
        .table_data       (table_data),
        .error            (error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [0:0] t, input int lo, input int hi,
                        input logic [3:0] cw, input logic esc, input logic [7:0] dat);
        table_push       = 1'b1;
        table_sel        = t;
        table_code_width = cw;
        table_escape     = esc;
        table_data       = dat;
        for (int i = lo; i <= hi; i++) begin
            table_addr = 8'(i);
            tick();
        end
        table_push = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        push = 1'b1;
        d    = w;
        tick();
        push = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (q_valid !== 1'b0 || q !== 8'h00 || error !== 1'b0 || full !== 1'b0 || half_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b q=%h err=%b full=%b hf=%b want all 0",
                     q_valid, q, error, full, half_full);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp [6] = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h41, 8'h41};
        load(1'b0, 8'h00, 8'h7F, 4'd1, 1'b0, 8'h41);
        load(1'b0, 8'h80, 8'hBF, 4'd2, 1'b0, 8'h42);
        load(1'b0, 8'hC0, 8'hFF, 4'd2, 1'b0, 8'h43);
        pop = 1'b1;
        push_word(8'b0101_1000);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (q_valid !== 1'b1 || q !== exp[i]) begin
                errors++;
                $display("FAIL basic_sym%0d: got v=%b q=%h want v=1 q=%h", i, q_valid, q, exp[i]);
            end
        end
        tick();
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained: got v=%b want v=0", q_valid);
        end
    endtask

    task automatic test_escape();
        load(1'b0, 8'hE0, 8'hFF, 4'd3, 1'b1, 8'h00);
        pop  = 1'b1;
        push = 1'b1;
        d    = 8'hE5;
        tick();
        d = 8'h40;
        tick();
        push = 1'b0;
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL esc_prefix: got v=%b want v=0", q_valid);
        end
        tick();
        checks++;
        if (q_valid !== 1'b1 || q !== 8'h2A) begin
            errors++;
            $display("FAIL esc_literal: got v=%b q=%h want v=1 q=2a", q_valid, q);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (q_valid !== 1'b1 || q !== 8'h41) begin
                errors++;
                $display("FAIL esc_tail%0d: got v=%b q=%h want v=1 q=41", i, q_valid, q);
            end
        end
        tick();
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL esc_drained: got v=%b want v=0", q_valid);
        end
    endtask

    task automatic test_backpressure();
        load(1'b0, 8'h00, 8'h00, 4'd8, 1'b0, 8'h11);
        pop  = 1'b0;
        push = 1'b1;
        d    = 8'h00;
        tick();
        tick();
        checks++;
        if (q_valid !== 1'b1 || q !== 8'h11 || half_full !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got v=%b q=%h hf=%b want v=1 q=11 hf=0", q_valid, q, half_full);
        end
        tick();
        checks++;
        if (half_full !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL bp_count16: got hf=%b full=%b want hf=1 full=0", half_full, full);
        end
        tick();
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL bp_count24: got full=%b want 0", full);
        end
        tick();
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL bp_count32: got full=%b want 1", full);
        end
        tick();
        push = 1'b0;
        checks++;
        if (q_valid !== 1'b1 || q !== 8'h11 || full !== 1'b1) begin
            errors++;
            $display("FAIL bp_held: got v=%b q=%h full=%b want v=1 q=11 full=1", q_valid, q, full);
        end
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (q_valid !== 1'b1 || q !== 8'h11) begin
                errors++;
                $display("FAIL bp_drain%0d: got v=%b q=%h want v=1 q=11", i, q_valid, q);
            end
        end
        tick();
        checks++;
        if (q_valid !== 1'b0 || full !== 1'b0 || half_full !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got v=%b full=%b hf=%b want all 0", q_valid, full, half_full);
        end
    endtask

    task automatic test_table_switch();
        logic [7:0] want;
        load(1'b0, 8'h00, 8'h7F, 4'd1, 1'b0, 8'h01);
        load(1'b1, 8'h00, 8'h7F, 4'd1, 1'b0, 8'h02);
        pop          = 1'b1;
        active_table = 1'b0;
        push_word(8'h00);
        for (int i = 0; i < 8; i++) begin
            active_table = 1'(i % 2);
            want         = (i % 2 == 0) ? 8'h01 : 8'h02;
            tick();
            checks++;
            if (q_valid !== 1'b1 || q !== want) begin
                errors++;
                $display("FAIL switch_sym%0d: got v=%b q=%h want v=1 q=%h", i, q_valid, q, want);
            end
        end
        active_table = 1'b0;
        tick();
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL switch_drained: got v=%b want v=0", q_valid);
        end
    endtask

    task automatic test_invalid();
        load(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 8'h00);
        pop = 1'b1;
        push_word(8'h00);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL inv_before: got err=%b want 0", error);
        end
        tick();
        checks++;
        if (error !== 1'b1 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_flag: got err=%b v=%b want err=1 v=0", error, q_valid);
        end
        push_word(8'h00);
        tick();
        checks++;
        if (error !== 1'b1 || q_valid !== 1'b0 || half_full !== 1'b1) begin
            errors++;
            $display("FAIL inv_halted: got err=%b v=%b hf=%b want err=1 v=0 hf=1", error, q_valid, half_full);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (error !== 1'b0 || half_full !== 1'b0) begin
            errors++;
            $display("FAIL inv_rst_clear: got err=%b hf=%b want 0 0", error, half_full);
        end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_escape();
        load(1'b0, 8'h00, 8'h7F, 4'd1, 1'b0, 8'h41);
        load(1'b0, 8'h80, 8'hFF, 4'd1, 1'b1, 8'h00);
        pop = 1'b1;
        push_word(8'h40);
        tick();
        checks++;
        if (q_valid !== 1'b1 || q !== 8'h41) begin
            errors++;
            $display("FAIL rme_first: got v=%b q=%h want v=1 q=41", q_valid, q);
        end
        tick();
        tick();
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL rme_in_esc: got v=%b want v=0", q_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q_valid !== 1'b0 || full !== 1'b0 || half_full !== 1'b0 || q !== 8'h00) begin
            errors++;
            $display("FAIL rme_async: got v=%b full=%b hf=%b q=%h want all 0", q_valid, full, half_full, q);
        end
        #1 rst = 1'b0;
        tick();
        push_word(8'h00);
        pop = 1'b0;
        tick();
        checks++;
        if (q_valid !== 1'b1 || q !== 8'h41) begin
            errors++;
            $display("FAIL rme_restart: got v=%b q=%h want v=1 q=41", q_valid, q);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q_valid !== 1'b0 || q !== 8'h00) begin
            errors++;
            $display("FAIL rme_rst_valid: got v=%b q=%h want v=0 q=00", q_valid, q);
        end
        #1 rst = 1'b0;
        tick();
        tick();
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL rme_buf_cleared: got v=%b want v=0", q_valid);
        end
    endtask

    initial begin
        push             = 1'b0;
        d                = 8'h00;
        pop              = 1'b0;
        active_table     = 1'b0;
        table_push       = 1'b0;
        table_sel        = 1'b0;
        table_addr       = 8'h00;
        table_code_width = 4'd0;
        table_escape     = 1'b0;
        table_data       = 8'h00;
        test_reset();
        test_basic();
        test_escape();
        test_backpressure();
        test_table_switch();
        test_invalid();
        test_reset_mid_escape();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
